sub_bytes_engine: RTL and testbench



---
 rtl/sub_bytes_engine.sv | 129 ++++++++++++
 tb/tb_sub_bytes_engine.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sub_bytes_engine.sv
// AES SubBytes/InvSubBytes, LANES bytes per cycle over 16/LANES passes; result valid NPASS+1 cycles after accept.
// Result is held stable in HOLD until out_ready; no new state is accepted until the result has been taken.
module sub_bytes_engine #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         inverse,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);
    localparam int NPASS = 16 / LANES;
    localparam int CW    = (NPASS > 1) ? $clog2(NPASS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NPASS - 1);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
    end

    localparam logic [7:0] FWD_SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    typedef enum logic [1:0] {IDLE, SUB, HOLD} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [127:0]  work_q, work_d;
    logic          mode_q, mode_d;
    logic          accept;
    logic [3:0]    lane_pos [LANES];
    logic [7:0]    lane_in  [LANES];
    logic [7:0]    lane_out [LANES];

    // Byte i sits at bits [8*(15-i) +: 8]; for a 4-bit index, 15-i == ~i.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_pos[l] = 4'(int'(cnt_q) * LANES + l);
        assign lane_in[l]  = work_q[{~lane_pos[l], 3'b000} +: 8];
        assign lane_out[l] = mode_q ? INV_SBOX[lane_in[l]] : FWD_SBOX[lane_in[l]];
    end

    assign accept    = in_valid && in_ready;
    assign state_out = work_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SUB;
            SUB:     if (cnt_q == LAST) state_d = HOLD;
            HOLD:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE) && !rst;
        out_valid = (state_q == HOLD);
        busy      = (state_q == SUB) || (state_q == HOLD);
    end

    always_comb begin
        work_d = work_q;
        mode_d = mode_q;
        cnt_d  = cnt_q;
        if (state_q == IDLE && accept) begin
            work_d = state_in;
            mode_d = inverse;
            cnt_d  = '0;
        end else if (state_q == SUB) begin
            for (int l = 0; l < LANES; l++) begin
                work_d[{~lane_pos[l], 3'b000} +: 8] = lane_out[l];
            end
            if (cnt_q != LAST) cnt_d = cnt_q + CW'(1);
        end
    end
endmodule

// File: tb/tb_sub_bytes_engine.sv
// Bench for sub_bytes_engine: five instances (LANES 1..16) against an algorithmic GF(2^8) S-box model.
module tb_sub_bytes_engine;
    localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

    logic         clk = 1'b0;
    logic         rst, inv, ordy;
    logic [127:0] sin;
    logic         iv [5];
    logic         ir [5];
    logic         ov [5];
    logic         bz [5];
    logic [127:0] so [5];

    int           total = 0;
    int           bad   = 0;
    logic [7:0]   fwd_t [256];
    logic [7:0]   inv_t [256];
    logic [127:0] exp_q [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 5; g++) begin : g_dut
        sub_bytes_engine #(.LANES(1 << g)) u_dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (iv[g]),
            .in_ready (ir[g]),
            .inverse  (inv),
            .state_in (sin),
            .out_valid(ov[g]),
            .out_ready(ordy),
            .state_out(so[g]),
            .busy     (bz[g])
        );
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a = a_in;
        logic [7:0] b = b_in;
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] y = 8'h00;
        for (int c = 1; c < 256; c++) if (gmul(x, 8'(c)) == 8'h01) y = 8'(c);
        return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s, input logic m);
        logic [127:0] r;
        for (int i = 0; i < 16; i++)
            r[127-8*i -: 8] = m ? inv_t[s[127-8*i -: 8]] : fwd_t[s[127-8*i -: 8]];
        return r;
    endfunction

    task automatic init_tables();
        logic [7:0] f;
        for (int b = 0; b < 256; b++) begin
            f = sbox_calc(8'(b));
            fwd_t[b] = f;
            inv_t[f] = 8'(b);
        end
    endtask

    // Presents one state and waits for acceptance; returns at the negedge of the cycle after the handshake.
    task automatic send(input int idx, input logic [127:0] d, input logic m, output bit ok);
        sin = d;
        inv = m;
        iv[idx] = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 100 && !ok; t++) begin
            if (ir[idx]) ok = 1'b1;
            else @(negedge clk);
        end
        if (ok) exp_q.push_back(model(d, m));
        @(negedge clk);
        iv[idx] = 1'b0;
    endtask

    // Full transaction with out_ready high; cyc counts cycles from the handshake cycle to out_valid.
    task automatic xact(input int idx, input logic [127:0] d, input logic m,
                        output int cyc, output logic [127:0] got, output logic [127:0] want);
        bit ok;
        send(idx, d, m, ok);
        cyc = 1;
        if (!ok) cyc = -1;
        else while (!ov[idx] && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        got  = so[idx];
        want = 'x;
        if (exp_q.size() > 0) want = exp_q.pop_front();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ordy = 1'b1;
        inv = 1'b0;
        sin = FIPS_IN;
        for (int i = 0; i < 5; i++) iv[i] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int i = 0; i < 5; i++) begin
                total++;
                if ({ir[i], ov[i], bz[i]} !== 3'b000) begin
                    bad++;
                    $display("FAIL reset_hold lanes=%0d cyc=%0d ir/ov/busy=%b%b%b required 000", 1 << i, c, ir[i], ov[i], bz[i]);
                end
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) iv[i] = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({ir[i], ov[i], bz[i]} !== 3'b100) begin
                bad++;
                $display("FAIL reset_release lanes=%0d ir/ov/busy=%b%b%b required 100", 1 << i, ir[i], ov[i], bz[i]);
            end
        end
    endtask

    task automatic test_fwd_all_lanes();
        int cyc;
        logic [127:0] got, want;
        for (int idx = 0; idx < 5; idx++) begin
            xact(idx, FIPS_IN, 1'b0, cyc, got, want);
            total++;
            if (cyc !== (16 >> idx) + 1) begin
                bad++;
                $display("FAIL fwd_latency lanes=%0d got=%0d required=%0d", 1 << idx, cyc, (16 >> idx) + 1);
            end
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL fwd_data lanes=%0d got=%h required=%h", 1 << idx, got, want);
            end
            total++;
            if (got !== FIPS_OUT) begin
                bad++;
                $display("FAIL fwd_fips lanes=%0d got=%h required=%h", 1 << idx, got, FIPS_OUT);
            end
        end
    endtask

    task automatic test_inverse();
        logic [127:0] vin [3];
        logic [127:0] vout [3];
        logic         vm [3];
        int cyc;
        logic [127:0] got, want;
        vin[0] = FIPS_OUT;      vm[0] = 1'b1; vout[0] = FIPS_IN;
        vin[1] = '0;            vm[1] = 1'b0; vout[1] = {16{8'h63}};
        vin[2] = {16{8'h63}};   vm[2] = 1'b1; vout[2] = '0;
        for (int idx = 2; idx < 4; idx++) begin
            for (int v = 0; v < 3; v++) begin
                xact(idx, vin[v], vm[v], cyc, got, want);
                total++;
                if (got !== want || got !== vout[v]) begin
                    bad++;
                    $display("FAIL inverse_vec%0d lanes=%0d got=%h required=%h", v, 1 << idx, got, vout[v]);
                end
            end
        end
    endtask

    task automatic test_sweep();
        int cyc;
        logic [127:0] d, got, want;
        for (int m = 0; m < 2; m++) begin
            for (int j = 0; j < 16; j++) begin
                for (int i = 0; i < 16; i++) d[127-8*i -: 8] = 8'(j * 16 + i);
                xact(4, d, 1'(m), cyc, got, want);
                total++;
                if (got !== want) begin
                    bad++;
                    $display("FAIL sweep mode=%0d row=%0d got=%h required=%h", m, j, got, want);
                end
                if (m == 0 && j == 5) begin
                    total++;
                    if (got[127-8*3 -: 8] !== 8'hed) begin
                        bad++;
                        $display("FAIL sbox_53 got=%h required=ed", got[127-8*3 -: 8]);
                    end
                end
                if (m == 0 && j == 15) begin
                    total++;
                    if (got[7:0] !== 8'h16) begin
                        bad++;
                        $display("FAIL sbox_ff got=%h required=16", got[7:0]);
                    end
                end
                if (m == 1 && j == 14) begin
                    total++;
                    if (got[127-8*13 -: 8] !== 8'h53) begin
                        bad++;
                        $display("FAIL invsbox_ed got=%h required=53", got[127-8*13 -: 8]);
                    end
                end
                if (m == 1 && j == 1) begin
                    total++;
                    if (got[127-8*6 -: 8] !== 8'hff) begin
                        bad++;
                        $display("FAIL invsbox_16 got=%h required=ff", got[127-8*6 -: 8]);
                    end
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int idx = 2;
        bit ok;
        int cyc, deliveries;
        logic [127:0] ref_v, got, want;
        ordy = 1'b0;
        send(idx, {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b1, ok);
        cyc = 1;
        while (ok && !ov[idx] && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (!ok || ov[idx] !== 1'b1) begin
            bad++;
            $display("FAIL bp_valid accepted=%0d out_valid=%b required 1/1", ok, ov[idx]);
        end
        ref_v = 'x;
        if (exp_q.size() > 0) ref_v = exp_q[0];
        for (int c = 0; c < 10; c++) begin
            total++;
            if (so[idx] !== ref_v || ir[idx] !== 1'b0 || ov[idx] !== 1'b1) begin
                bad++;
                $display("FAIL bp_hold cyc=%0d out=%h ir=%b ov=%b required out=%h ir=0 ov=1", c, so[idx], ir[idx], ov[idx], ref_v);
            end
            iv[idx] = 1'($urandom());
            inv = 1'($urandom());
            sin = {$urandom(), $urandom(), $urandom(), $urandom()};
            @(negedge clk);
        end
        iv[idx] = 1'b0;
        ordy = 1'b1;
        deliveries = 0;
        got = '0;
        for (int c = 0; c < 6; c++) begin
            if (ov[idx]) begin
                deliveries++;
                got = so[idx];
            end
            @(negedge clk);
        end
        total++;
        if (deliveries !== 1) begin
            bad++;
            $display("FAIL bp_deliveries got=%0d required=1", deliveries);
        end
        want = 'x;
        if (exp_q.size() > 0) want = exp_q.pop_front();
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL bp_data got=%h required=%h", got, want);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int cyc, seen;
        logic [127:0] got, want;
        send(1, {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0, ok);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        if (ok) void'(exp_q.pop_back());
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            if (ov[1]) seen++;
            @(negedge clk);
        end
        total++;
        if (seen !== 0 || ir[1] !== 1'b1) begin
            bad++;
            $display("FAIL abort out_valid_cycles=%0d ir=%b required 0 and ir=1", seen, ir[1]);
        end
        xact(1, FIPS_IN, 1'b0, cyc, got, want);
        total++;
        if (cyc !== 9) begin
            bad++;
            $display("FAIL abort_latency got=%0d required=9", cyc);
        end
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL abort_data got=%h required=%h", got, want);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic m;
        logic [127:0] d, got, want;
        for (int idx = 0; idx < 5; idx++) begin
            for (int n = 0; n < 3; n++) begin
                d = {$urandom(), $urandom(), $urandom(), $urandom()};
                m = 1'($urandom());
                xact(idx, d, m, cyc, got, want);
                total++;
                if (got !== want || cyc !== (16 >> idx) + 1) begin
                    bad++;
                    $display("FAIL b2b lanes=%0d n=%0d got=%h lat=%0d required=%h lat=%0d", 1 << idx, n, got, cyc, want, (16 >> idx) + 1);
                end
                total++;
                if (ir[idx] !== 1'b1 || ov[idx] !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_idle lanes=%0d ir=%b ov=%b required ir=1 ov=0", 1 << idx, ir[idx], ov[idx]);
                end
            end
        end
    endtask

    initial begin
        init_tables();
        test_reset();
        test_fwd_all_lanes();
        test_inverse();
        test_sweep();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
